c7b_axi_rd_arb: RTL and testbench

//  Shares the single AXI read channel of the c7b core between instruction fetch (IFU) and load (LSU).

---
 rtl/c7b_axi_rd_arb_if.sv | 33 +++
 rtl/c7b_axi_rd_arb.sv | 126 ++++++++++++
 tb/tb_c7b_axi_rd_arb.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c7b_axi_rd_arb_if.sv
// AXI read address/data channel bundle between the c7b read arbiter and the top-level AXI port.
interface c7b_axi_rd_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/c7b_axi_rd_arb.sv
// Round-robin share of one single-beat AXI read channel between IFU and LSU;
// one transaction in flight, R beat steered back to the owner of the outstanding AR.
module c7b_axi_rd_arb #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] ID_IFU = 4'd0,
  parameter logic [3:0] ID_LSU = 4'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_ack,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rerr,
  input  logic              lsu_req,
  input  logic [ADDR_W-1:0] lsu_addr,
  output logic              lsu_ack,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rerr,
  c7b_axi_rd_arb_if.master  axi,
  output logic              id_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state, state_nx;
  logic              owner_lsu;
  logic              rr_last_lsu;
  logic [ADDR_W-1:0] araddr_p0;
  logic [3:0]        arid_p0;
  logic              any_req, grant_lsu, ar_hs, r_hs;

  logic              ifu_ack_p1, lsu_ack_p1;
  logic              ifu_vld_p1, lsu_vld_p1;
  logic [DATA_W-1:0] ifu_rdata_p1, lsu_rdata_p1;
  logic              ifu_rerr_p1, lsu_rerr_p1;
  logic              id_err_q;

  // Single-beat transactions complete on the one R beat, so rlast carries no information.
  logic              unused_rlast;
  assign unused_rlast = axi.rlast;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != 2'b00;
  endfunction

  always_comb begin
    state_nx  = state;
    any_req   = ifu_req | lsu_req;
    // On a tie the requester that was not served last wins.
    grant_lsu = lsu_req & (~ifu_req | ~rr_last_lsu);
    ar_hs     = (state == ADDR) & axi.arready;
    r_hs      = (state == DATA) & axi.rvalid;
    case (state)
      IDLE:    if (any_req)    state_nx = ADDR;
      ADDR:    if (axi.arready) state_nx = DATA;
      DATA:    if (axi.rvalid)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: grant capture and AR issue; stage p1: registered ack / return beat
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner_lsu    <= 1'b0;
      rr_last_lsu  <= 1'b0;
      araddr_p0    <= '0;
      arid_p0      <= '0;
      ifu_ack_p1   <= 1'b0;
      lsu_ack_p1   <= 1'b0;
      ifu_vld_p1   <= 1'b0;
      lsu_vld_p1   <= 1'b0;
      ifu_rdata_p1 <= '0;
      lsu_rdata_p1 <= '0;
      ifu_rerr_p1  <= 1'b0;
      lsu_rerr_p1  <= 1'b0;
      id_err_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      ifu_ack_p1 <= ar_hs & ~owner_lsu;
      lsu_ack_p1 <= ar_hs &  owner_lsu;
      ifu_vld_p1 <= r_hs  & ~owner_lsu;
      lsu_vld_p1 <= r_hs  &  owner_lsu;
      if ((state == IDLE) && any_req) begin
        owner_lsu   <= grant_lsu;
        rr_last_lsu <= grant_lsu;
        araddr_p0   <= grant_lsu ? lsu_addr : ifu_addr;
        arid_p0     <= grant_lsu ? ID_LSU : ID_IFU;
      end
      if (r_hs) begin
        if (owner_lsu) begin
          lsu_rdata_p1 <= axi.rdata;
          lsu_rerr_p1  <= resp_is_err(axi.rresp);
        end else begin
          ifu_rdata_p1 <= axi.rdata;
          ifu_rerr_p1  <= resp_is_err(axi.rresp);
        end
        // A stray id still delivers data to the owner; the flag only records it.
        if (axi.rid != arid_p0) id_err_q <= 1'b1;
      end
    end
  end

  assign axi.arid    = arid_p0;
  assign axi.araddr  = araddr_p0;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = (state == ADDR);
  assign axi.rready  = (state == DATA);

  assign ifu_ack    = ifu_ack_p1;
  assign lsu_ack    = lsu_ack_p1;
  assign ifu_rvalid = ifu_vld_p1;
  assign lsu_rvalid = lsu_vld_p1;
  assign ifu_rdata  = ifu_rdata_p1;
  assign lsu_rdata  = lsu_rdata_p1;
  assign ifu_rerr   = ifu_rerr_p1;
  assign lsu_rerr   = lsu_rerr_p1;
  assign id_err     = id_err_q;

endmodule

// File: tb/tb_c7b_axi_rd_arb.sv
// Directed bench for c7b_axi_rd_arb: the bench plays the AXI slave and both requesters.
module tb_c7b_axi_rd_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req, lsu_req;
  logic [31:0] ifu_addr, lsu_addr;
  logic        ifu_ack, ifu_rvalid, ifu_rerr;
  logic        lsu_ack, lsu_rvalid, lsu_rerr;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic        id_err;

  c7b_axi_rd_arb_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  c7b_axi_rd_arb #(.ADDR_W(32), .DATA_W(32), .ID_IFU(4'd0), .ID_LSU(4'd1)) dut (
    .clk(clk), .reset(reset),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ack(ifu_ack),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rerr(ifu_rerr),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_ack(lsu_ack),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rerr(lsu_rerr),
    .axi(axi), .id_err(id_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Observations gathered by the transaction driver
  logic        o_timeout, o_both, o_stable, o_early_ack, o_rready_addr, o_early_rv;
  int          o_arv_lat;
  logic [3:0]  o_arid;
  logic [31:0] o_araddr;
  logic        o_ack_i, o_ack_l, o_rready, o_arvalid_after;
  logic        o_rv_i, o_rv_l, o_ack_held, o_rready_after;
  logic [31:0] o_rdata_i, o_rdata_l;
  logic        o_rerr_i, o_rerr_l;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_both();
    if ((ifu_ack && lsu_ack) || (ifu_rvalid && lsu_rvalid)) o_both = 1'b1;
  endtask

  task automatic txn(input logic ireq, input logic lreq,
                     input logic [31:0] iaddr, input logic [31:0] laddr,
                     input int ar_wait, input logic rv_early,
                     input logic [3:0] r_id, input logic [31:0] r_data,
                     input logic [1:0] r_resp, input logic r_last);
    int n;
    o_timeout = 0; o_both = 0; o_stable = 1; o_early_ack = 0;
    o_rready_addr = 0; o_early_rv = 0;
    ifu_req = ireq; ifu_addr = iaddr;
    lsu_req = lreq; lsu_addr = laddr;
    axi.arready = 1'b0; axi.rvalid = 1'b0;
    n = 0;
    do begin
      tick(); note_both(); n++;
    end while (!axi.arvalid && n < 8);
    o_arv_lat = n;
    if (!axi.arvalid) o_timeout = 1'b1;
    o_arid = axi.arid; o_araddr = axi.araddr;
    for (int i = 0; i < ar_wait; i++) begin
      if (rv_early) begin
        axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_BEEF; axi.rid = o_arid; axi.rresp = 2'b00;
      end
      tick(); note_both();
      if (axi.arvalid !== 1'b1 || axi.araddr !== o_araddr || axi.arid !== o_arid) o_stable = 1'b0;
      if (ifu_ack || lsu_ack) o_early_ack = 1'b1;
      if (axi.rready) o_rready_addr = 1'b1;
      if (ifu_rvalid || lsu_rvalid) o_early_rv = 1'b1;
    end
    axi.rvalid = 1'b0; axi.arready = 1'b1;
    tick(); note_both();
    o_ack_i = ifu_ack; o_ack_l = lsu_ack;
    o_rready = axi.rready; o_arvalid_after = axi.arvalid;
    if (ifu_ack) ifu_req = 1'b0;
    if (lsu_ack) lsu_req = 1'b0;
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rid = r_id; axi.rdata = r_data; axi.rresp = r_resp; axi.rlast = r_last;
    tick(); note_both();
    o_rv_i = ifu_rvalid; o_rv_l = lsu_rvalid;
    o_ack_held = ifu_ack | lsu_ack;
    o_rdata_i = ifu_rdata; o_rerr_i = ifu_rerr;
    o_rdata_l = lsu_rdata; o_rerr_l = lsu_rerr;
    o_rready_after = axi.rready;
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    vectors++;
    if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0) begin
      miscompares++; $display("FAIL reset_axi arvalid=%b rready=%b expected 0 0", axi.arvalid, axi.rready);
    end
    vectors++;
    if ({ifu_ack, lsu_ack, ifu_rvalid, lsu_rvalid, ifu_rerr, lsu_rerr, id_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl ack/rvalid/rerr/id_err=%b expected 0000000",
               {ifu_ack, lsu_ack, ifu_rvalid, lsu_rvalid, ifu_rerr, lsu_rerr, id_err});
    end
    vectors++;
    if (ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_data ifu=%h lsu=%h expected 0 0", ifu_rdata, lsu_rdata);
    end
    vectors++;
    if (axi.arlen !== 8'd0 || axi.arsize !== 3'b010 || axi.arburst !== 2'b01) begin
      miscompares++;
      $display("FAIL ar_consts len=%h size=%b burst=%b expected 00 010 01", axi.arlen, axi.arsize, axi.arburst);
    end
    reset = 1'b0;
  endtask

  task automatic test_ifu_only();
    txn(1'b1, 1'b0, 32'h1c00_0000, 32'h0, 0, 1'b0, 4'd0, 32'h0280_0405, 2'b00, 1'b1);
    vectors++;
    if (o_timeout !== 1'b0 || o_arv_lat !== 1) begin
      miscompares++; $display("FAIL t1_arvalid_latency got %0d (timeout %b) expected 1", o_arv_lat, o_timeout);
    end
    vectors++;
    if (o_arid !== 4'd0 || o_araddr !== 32'h1c00_0000) begin
      miscompares++; $display("FAIL t1_ar got id=%h addr=%h expected 0 1c000000", o_arid, o_araddr);
    end
    vectors++;
    if (o_ack_i !== 1'b1 || o_ack_l !== 1'b0 || o_rready !== 1'b1 || o_arvalid_after !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_ack got ifu=%b lsu=%b rready=%b arvalid=%b expected 1 0 1 0",
               o_ack_i, o_ack_l, o_rready, o_arvalid_after);
    end
    vectors++;
    if (o_rv_i !== 1'b1 || o_rv_l !== 1'b0 || o_rdata_i !== 32'h0280_0405 || o_rerr_i !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_rdata got rv=%b lsu_rv=%b data=%h err=%b expected 1 0 02800405 0",
               o_rv_i, o_rv_l, o_rdata_i, o_rerr_i);
    end
    vectors++;
    if (o_ack_held !== 1'b0 || o_rready_after !== 1'b0) begin
      miscompares++; $display("FAIL t1_pulse got ack=%b rready=%b expected 0 0", o_ack_held, o_rready_after);
    end
    tick();
    vectors++;
    if (ifu_rvalid !== 1'b0 || axi.arvalid !== 1'b0) begin
      miscompares++; $display("FAIL t1_idle got rvalid=%b arvalid=%b expected 0 0", ifu_rvalid, axi.arvalid);
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_id [6];
    logic       ireq_t [6];
    logic       lreq_t [6];
    exp_id = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
    ireq_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    lreq_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    reset = 1'b1; tick(); reset = 1'b0;
    // tie(LSU) IFU tie(LSU) IFU LSU tie(IFU) LSU
    for (int k = 0; k < 6; k++) begin
      txn(ireq_t[k], lreq_t[k], 32'h0000_1000 + 32'(k), 32'h0000_2000 + 32'(k), 0, 1'b0,
          exp_id[k], 32'hA000_0000 + 32'(k), 2'b00, 1'b1);
      vectors++;
      if (o_timeout !== 1'b0 || o_arid !== exp_id[k] ||
          o_araddr !== (exp_id[k] == 4'd1 ? 32'h0000_2000 : 32'h0000_1000) + 32'(k)) begin
        miscompares++;
        $display("FAIL t2_grant%0d got id=%h addr=%h timeout=%b expected id %h", k, o_arid, o_araddr, o_timeout, exp_id[k]);
      end
      vectors++;
      if (o_ack_l !== exp_id[k][0] || o_ack_i !== ~exp_id[k][0] ||
          o_rv_l !== exp_id[k][0] || o_rv_i !== ~exp_id[k][0] || o_both !== 1'b0) begin
        miscompares++;
        $display("FAIL t2_route%0d got ack i/l=%b%b rv i/l=%b%b both=%b", k, o_ack_i, o_ack_l, o_rv_i, o_rv_l, o_both);
      end
    end
    txn(1'b0, 1'b1, 32'h0, 32'h0000_2006, 0, 1'b0, 4'd1, 32'hA000_0006, 2'b00, 1'b1);
    vectors++;
    if (o_arid !== 4'd1 || o_rv_l !== 1'b1 || o_rdata_l !== 32'hA000_0006 || o_arv_lat !== 1) begin
      miscompares++;
      $display("FAIL t2_pending got id=%h rv=%b data=%h lat=%0d expected 1 1 a0000006 1", o_arid, o_rv_l, o_rdata_l, o_arv_lat);
    end
  endtask

  task automatic test_ar_stall();
    txn(1'b1, 1'b0, 32'h0000_4a40, 32'h0, 5, 1'b1, 4'd0, 32'h1234_5678, 2'b00, 1'b1);
    vectors++;
    if (o_stable !== 1'b1 || o_early_ack !== 1'b0) begin
      miscompares++; $display("FAIL t3_stall got stable=%b early_ack=%b expected 1 0", o_stable, o_early_ack);
    end
    vectors++;
    if (o_rready_addr !== 1'b0 || o_early_rv !== 1'b0) begin
      miscompares++; $display("FAIL t3_rvalid_in_addr got rready=%b rv=%b expected 0 0", o_rready_addr, o_early_rv);
    end
    vectors++;
    if (o_ack_i !== 1'b1 || o_rv_i !== 1'b1 || o_rdata_i !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL t3_complete got ack=%b rv=%b data=%h expected 1 1 12345678", o_ack_i, o_rv_i, o_rdata_i);
    end
  endtask

  task automatic test_rresp_err();
    txn(1'b0, 1'b1, 32'h0, 32'h0000_8000, 0, 1'b0, 4'd1, 32'hCAFE_F00D, 2'b10, 1'b0);
    vectors++;
    if (o_rv_l !== 1'b1 || o_rerr_l !== 1'b1 || o_rdata_l !== 32'hCAFE_F00D || o_rv_i !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_slverr got rv=%b err=%b data=%h ifu_rv=%b expected 1 1 cafef00d 0", o_rv_l, o_rerr_l, o_rdata_l, o_rv_i);
    end
    txn(1'b0, 1'b1, 32'h0, 32'h0000_8004, 0, 1'b0, 4'd1, 32'h0000_0042, 2'b00, 1'b1);
    vectors++;
    if (o_rv_l !== 1'b1 || o_rerr_l !== 1'b0 || o_rdata_l !== 32'h0000_0042) begin
      miscompares++; $display("FAIL t4_okay got rv=%b err=%b data=%h expected 1 0 00000042", o_rv_l, o_rerr_l, o_rdata_l);
    end
    vectors++;
    if (id_err !== 1'b0) begin
      miscompares++; $display("FAIL t4_no_id_err got %b expected 0", id_err);
    end
  endtask

  task automatic test_id_err();
    txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 1'b0, 4'd1, 32'h0BAD_C0DE, 2'b00, 1'b1);
    vectors++;
    if (id_err !== 1'b1 || o_rv_i !== 1'b1 || o_rdata_i !== 32'h0BAD_C0DE || o_rv_l !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_mismatch got id_err=%b rv=%b data=%h lsu_rv=%b expected 1 1 0badc0de 0", id_err, o_rv_i, o_rdata_i, o_rv_l);
    end
    txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, 1'b0, 4'd0, 32'h0000_1111, 2'b00, 1'b1);
    vectors++;
    if (id_err !== 1'b1) begin
      miscompares++; $display("FAIL t5_sticky got %b expected 1", id_err);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++;
    if (id_err !== 1'b0) begin
      miscompares++; $display("FAIL t5_cleared got %b expected 0", id_err);
    end
  endtask

  task automatic test_reset_in_data();
    ifu_req = 1'b1; ifu_addr = 32'h0000_0200; lsu_req = 1'b0;
    axi.arready = 1'b1; axi.rvalid = 1'b0;
    tick(); tick();
    ifu_req = 1'b0; axi.arready = 1'b0;
    vectors++;
    if (axi.rready !== 1'b1 || ifu_ack !== 1'b1) begin
      miscompares++; $display("FAIL t6_in_data got rready=%b ack=%b expected 1 1", axi.rready, ifu_ack);
    end
    reset = 1'b1;
    axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'h5555_AAAA; axi.rresp = 2'b00; axi.rlast = 1'b1;
    tick();
    vectors++;
    if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0 || ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || ifu_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_reset got arvalid=%b rready=%b rv i/l=%b%b ack=%b expected all 0",
               axi.arvalid, axi.rready, ifu_rvalid, lsu_rvalid, ifu_ack);
    end
    reset = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    tick();
    vectors++;
    if (ifu_rvalid !== 1'b0 || ifu_rdata !== 32'h0) begin
      miscompares++; $display("FAIL t6_no_return got rv=%b data=%h expected 0 00000000", ifu_rvalid, ifu_rdata);
    end
    txn(1'b1, 1'b1, 32'h0000_0300, 32'h0000_0400, 0, 1'b0, 4'd1, 32'h7777_0001, 2'b00, 1'b1);
    vectors++;
    if (o_arid !== 4'd1 || o_araddr !== 32'h0000_0400 || o_rv_l !== 1'b1) begin
      miscompares++; $display("FAIL t6_first_tie got id=%h addr=%h rv=%b expected 1 00000400 1", o_arid, o_araddr, o_rv_l);
    end
    txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 0, 1'b0, 4'd0, 32'h7777_0002, 2'b00, 1'b1);
    vectors++;
    if (o_arid !== 4'd0 || o_rv_i !== 1'b1 || o_rdata_i !== 32'h7777_0002) begin
      miscompares++; $display("FAIL t6_second got id=%h rv=%b data=%h expected 0 1 77770002", o_arid, o_rv_i, o_rdata_i);
    end
  endtask

  initial begin
    reset = 1'b1;
    ifu_req = 1'b0; lsu_req = 1'b0; ifu_addr = '0; lsu_addr = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0;
    axi.rresp = '0; axi.rlast = 1'b0;
    test_reset();
    test_ifu_only();
    test_arbitration();
    test_ar_stall();
    test_rresp_err();
    test_id_err();
    test_reset_in_data();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
